// File: rtl/gate_bist_pkg.sv
// Shared constants for the gate BIST engine: gate-function codes, FSM state
// encoding and a helper that screens out the reserved mode codes.
package gate_bist_pkg;

  localparam int ST_W = 2;

  localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [ST_W-1:0] ST_APPLY = 2'd1;
  localparam logic [ST_W-1:0] ST_CHECK = 2'd2;
  localparam logic [ST_W-1:0] ST_DONE  = 2'd3;

  localparam logic [2:0] MODE_AND  = 3'd0;
  localparam logic [2:0] MODE_OR   = 3'd1;
  localparam logic [2:0] MODE_NAND = 3'd2;
  localparam logic [2:0] MODE_NOR  = 3'd3;
  localparam logic [2:0] MODE_XOR  = 3'd4;
  localparam logic [2:0] MODE_XNOR = 3'd5;

  // Codes 6 and 7 have no golden function and must never start a run.
  function automatic logic mode_legal(input logic [2:0] m);
    return (m <= MODE_XNOR);
  endfunction

endpackage

// File: rtl/gate_bist_model.sv
// Combinational golden reference for an N_IN-input gate. Kept separate so
// benches can reuse it. Reserved mode codes yield 0 (never used by the engine).
module gate_model
  import gate_bist_pkg::*;
#(
  parameter int N_IN = 2
) (
  input  logic [2:0]      mode,
  input  logic [N_IN-1:0] pat,
  output logic            exp
);

  // Select the reduction matching the requested gate function.
  always_comb begin
    exp = 1'b0;
    case (mode)
      MODE_AND:  exp = &pat;
      MODE_OR:   exp = |pat;
      MODE_NAND: exp = ~&pat;
      MODE_NOR:  exp = ~|pat;
      MODE_XOR:  exp = ^pat;
      MODE_XNOR: exp = ~^pat;
      default:   exp = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_bist.sv
// Built-in self-test engine for an external N_IN-input combinational gate.
// Walks every input pattern, holds each for SETTLE cycles, samples the gate
// output for one CHECK cycle and counts mismatches (saturating).
// Optional first-failure capture is built when GATE_BIST_FIRST_FAIL_EN is
// defined (adds first_fail_vld / first_fail_pat).
module gate_bist
  import gate_bist_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1,
  parameter int ERR_W  = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [2:0]       mode,
  output logic [N_IN-1:0]  pat_out,
  input  logic             dut_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count
`ifdef GATE_BIST_FIRST_FAIL_EN
  ,
  output logic             first_fail_vld,
  output logic [N_IN-1:0]  first_fail_pat
`endif
);

  // A one-cycle settle interval needs no real counter; keep a 1-bit stub.
  localparam int SC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  logic [ST_W-1:0]  state_r;
  logic [SC_W-1:0]  settle_cnt_r;
  logic [N_IN-1:0]  pat_r;
  logic [2:0]       mode_r;
  logic [ERR_W-1:0] err_r;
  logic             busy_r;
  logic             done_r;

  logic accept_s;
  logic exp_s;
  logic mismatch_s;
  logic last_pat_s;
  logic settle_last_s;
  logic err_sat_s;

  gate_model #(.N_IN(N_IN)) u_model (
    .mode (mode_r),
    .pat  (pat_r),
    .exp  (exp_s)
  );

  assign accept_s      = start && mode_legal(mode) &&
                         ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign mismatch_s    = (state_r == ST_CHECK) && (dut_in != exp_s);
  assign last_pat_s    = (pat_r == {N_IN{1'b1}});
  assign settle_last_s = (settle_cnt_r == SC_W'(SETTLE - 1));
  assign err_sat_s     = (err_r == {ERR_W{1'b1}});

  // Run sequencer: settle timing, pattern walk and mismatch counting.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r      <= ST_IDLE;
      settle_cnt_r <= {SC_W{1'b0}};
      pat_r        <= {N_IN{1'b0}};
      mode_r       <= MODE_AND;
      err_r        <= {ERR_W{1'b0}};
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (accept_s) begin
            mode_r       <= mode;
            pat_r        <= {N_IN{1'b0}};
            err_r        <= {ERR_W{1'b0}};
            settle_cnt_r <= {SC_W{1'b0}};
            done_r       <= 1'b0;
            busy_r       <= 1'b1;
            state_r      <= ST_APPLY;
          end else begin
            state_r <= state_r;
          end
        end
        ST_APPLY: begin
          if (settle_last_s) begin
            settle_cnt_r <= {SC_W{1'b0}};
            state_r      <= ST_CHECK;
          end else begin
            settle_cnt_r <= settle_cnt_r + SC_W'(1'b1);
          end
        end
        ST_CHECK: begin
          if (mismatch_s && !err_sat_s) begin
            err_r <= err_r + ERR_W'(1'b1);
          end else begin
            err_r <= err_r;
          end
          if (last_pat_s) begin
            pat_r   <= {N_IN{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            pat_r   <= pat_r + N_IN'(1'b1);
            state_r <= ST_APPLY;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef GATE_BIST_FIRST_FAIL_EN
  logic            ff_vld_r;
  logic [N_IN-1:0] ff_pat_r;

  // Capture the pattern of the first mismatch of each run; later ones are dropped.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ff_vld_r <= 1'b0;
      ff_pat_r <= {N_IN{1'b0}};
    end else if (accept_s) begin
      ff_vld_r <= 1'b0;
      ff_pat_r <= {N_IN{1'b0}};
    end else if (mismatch_s && !ff_vld_r) begin
      ff_vld_r <= 1'b1;
      ff_pat_r <= pat_r;
    end else begin
      ff_vld_r <= ff_vld_r;
      ff_pat_r <= ff_pat_r;
    end
  end

  assign first_fail_vld = ff_vld_r;
  assign first_fail_pat = ff_pat_r;
`endif

  assign pat_out   = pat_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err_count = err_r;
  assign pass      = done_r && (err_r == {ERR_W{1'b0}});

endmodule
